// File: rtl/seed_round_ctrl_if.sv
// Host-side bundle for seed_round_ctrl.
//   i_Start     start pulse, i_Data sampled in the same cycle
//   i_Data      128-bit plaintext {L0,L1,R0,R1}
//   i_RoundKey  {K0,K1} for the round on o_KeyIdx, combinational from the key block
//   o_KeyIdx    round index presented to the key block
//   o_Busy      operation in flight
//   o_Valid     one-cycle pulse, o_Data carries the ciphertext
//   o_Data      ciphertext, held until overwritten by the next result
//   dbg_state   current controller state, for checkers and debug
//
// Handshake: a start is accepted only when the block is idle (o_Busy=0 and
// no o_Valid pulse in that cycle); i_Start in any other cycle has no effect.
// There is no back-pressure on o_Valid: the consumer must take o_Data in the
// pulse cycle or later while it is held.
interface seed_round_ctrl_if;
  logic         i_Start;
  logic [127:0] i_Data;
  logic [63:0]  i_RoundKey;
  logic [3:0]   o_KeyIdx;
  logic         o_Busy;
  logic         o_Valid;
  logic [127:0] o_Data;
  logic [2:0]   dbg_state;

  modport master (
    output i_Start, i_Data, i_RoundKey,
    input  o_KeyIdx, o_Busy, o_Valid, o_Data, dbg_state
  );

  modport slave (
    input  i_Start, i_Data, i_RoundKey,
    output o_KeyIdx, o_Busy, o_Valid, o_Data, dbg_state
  );
endinterface

// File: rtl/seed_round_ctrl.sv
// SEED-128 encryption sequencer built around a single shared G unit.
// Each Feistel round is LOAD (key mix) followed by three G steps; the G
// input is multiplexed so only one G evaluation happens per step.
// Ports:
//   i_Clk    rising-edge clock
//   i_Rst_n  asynchronous active-low reset
//   bus      seed_round_ctrl_if.slave (start/data in, key request, result out)
// Parameters:
//   NUM_ROUNDS  number of Feistel rounds (16 for SEED-128, at most 16)
//   G_REG       0: G result used in the same cycle; 1: G output registered,
//               each G step then takes two cycles
module seed_round_ctrl #(
  parameter int NUM_ROUNDS = 16,
  parameter bit G_REG      = 1'b0
) (
  input logic              i_Clk,
  input logic              i_Rst_n,
  seed_round_ctrl_if.slave bus
);

  // SEED S-boxes, entry 0 in the most significant byte.
  localparam logic [2047:0] S1_TAB = {
    128'hA985D6D3541DAC255D43181E51FCCA63, 128'h2844209DE0E2C817A58F037BBB13D2EE,
    128'h708C3FA832DDF674EC950B575C5BBD01, 128'h241C739810CCF2D92CE772839BD186C9,
    128'h6050A3EB0DB69E4FB75AC678A612AFD5, 128'h61C3B441527D8D081F9900190453F7E1,
    128'hFD762F27B08B0EABA26E934D697C090A, 128'hBFEFF3C58714FE64DE2E4B1A06216B66,
    128'h02F5928A0CB37ED07A4796E52680ADDF, 128'hA13037AE36152238F4A7454C81E98497,
    128'h35CBCE3C7111C78975FBDAF8945982C4, 128'hFF493967C0CFD7B80F8E4223916CDBA4,
    128'h34F148C26F3D2D40BE3EBCC1AABA4E55, 128'h3BDC687F9CD84A5677A0ED46B52B65FA,
    128'hE3B9B19F5EF9E6B231EA6D5FE4F0CD88, 128'h163A58D462290733E81B0579906A2A9A
  };
  localparam logic [2047:0] S2_TAB = {
    128'h38E82DA6CFDEB3B8AF6055C7446F6B5B, 128'hC36233B529A0E2A7D39111061CBC364B,
    128'hEF886CA817C416F4C245E1D63F3D8E98, 128'h284EF63EA5F90DDFD82B667A272FF172,
    128'h42D441C07367AC8BF7AD801FCA2CAA34, 128'hD20BEEE95D9418F857AE08C513CD86B9,
    128'hFF7DC131F58A6AB1D120D70222046871, 128'h07DB9D9961BEE659DD5190DC9AA3ABD0,
    128'h810F471AE3EC8DBF967B5CA2A163234D, 128'hC89E9C3A0C2EBA6E9F5AF292F34978CC,
    128'h15FB70757F351003646DC674D5B4EA09, 128'h7619FE4012E0BD05FA01F02A5EA95643,
    128'h8514899BB0E5487997FC1E82218C1B5F, 128'h7754B21D254F0046ED5852EB7EDAC9FD,
    128'h3095653CB6E4BB7C0E50392632846993, 128'h37E724A4CB530A87D94C838FCE3B4AB7
  };
  localparam logic [7:0] M0 = 8'hFC;
  localparam logic [7:0] M1 = 8'hF3;
  localparam logic [7:0] M2 = 8'hCF;
  localparam logic [7:0] M3 = 8'h3F;
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LOAD = 3'd1, S_G1 = 3'd2, S_G2 = 3'd3, S_G3 = 3'd4, S_DONE = 3'd5
  } state_t;

  // MSB index of entry x is 2047 - 8*x = {~x, 3'b111}.
  function automatic logic [7:0] sbox1(input logic [7:0] x);
    return S1_TAB[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] sbox2(input logic [7:0] x);
    return S2_TAB[{~x, 3'b111} -: 8];
  endfunction

  // G = SS3 ^ SS2 ^ SS1 ^ SS0; each SSn is its S-box byte masked per lane.
  function automatic logic [31:0] g_fn(input logic [31:0] x);
    logic [7:0] a, b, c, e;
    a = sbox1(x[7:0]);
    b = sbox2(x[15:8]);
    c = sbox1(x[23:16]);
    e = sbox2(x[31:24]);
    return {a & M3, a & M2, a & M1, a & M0} ^
           {b & M0, b & M3, b & M2, b & M1} ^
           {c & M1, c & M0, c & M3, c & M2} ^
           {e & M2, e & M1, e & M0, e & M3};
  endfunction

  state_t       state_q, state_d;
  logic [63:0]  l_q, r_q;
  logic [31:0]  c_q, d_q, g_q;
  logic [3:0]   round_q;
  logic         phase_q;
  logic [127:0] data_q;

  logic         in_g, step_done, last_round;
  logic [31:0]  g_in, g_out, g_val, c2;
  logic [63:0]  lf;

  assign in_g       = state_q inside {S_G1, S_G2, S_G3};
  // With a registered G, the first cycle of a step loads g_q and the second consumes it.
  assign step_done  = !G_REG || phase_q;
  assign last_round = (round_q == LAST_ROUND);

  // G1 sees C'^D'; G2 (D1+C') and G3 (C1+D1) are both c+d given the register updates.
  always_comb begin
    g_in = c_q + d_q;
    if (state_q == S_G1) g_in = c_q ^ d_q;
  end

  assign g_out = g_fn(g_in);
  assign g_val = G_REG ? g_q : g_out;
  assign c2    = c_q + g_val;
  assign lf    = l_q ^ {c2, g_val};

  // State register
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.i_Start) state_d = S_LOAD;
      S_LOAD:  state_d = S_G1;
      S_G1:    if (step_done) state_d = S_G2;
      S_G2:    if (step_done) state_d = S_G3;
      S_G3:    if (step_done) state_d = last_round ? S_DONE : S_LOAD;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.o_Busy   = 1'b0;
    bus.o_Valid  = 1'b0;
    bus.o_KeyIdx = 4'd0;
    case (state_q)
      S_LOAD, S_G1, S_G2, S_G3: begin
        bus.o_Busy   = 1'b1;
        bus.o_KeyIdx = round_q;
      end
      S_DONE:  bus.o_Valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.o_Data    = data_q;
  assign bus.dbg_state = state_q;

  // Datapath
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      l_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      g_q     <= '0;
      round_q <= '0;
      phase_q <= 1'b0;
      data_q  <= '0;
    end else begin
      phase_q <= G_REG && in_g && !phase_q;
      if (G_REG) g_q <= g_out;
      case (state_q)
        S_IDLE: if (bus.i_Start) begin
          l_q     <= bus.i_Data[127:64];
          r_q     <= bus.i_Data[63:0];
          round_q <= '0;
        end
        S_LOAD: begin
          c_q <= r_q[63:32] ^ bus.i_RoundKey[63:32];
          d_q <= r_q[31:0]  ^ bus.i_RoundKey[31:0];
        end
        S_G1: if (step_done) d_q <= g_val;
        S_G2: if (step_done) c_q <= g_val;
        S_G3: if (step_done) begin
          if (last_round) begin
            // Final round keeps the halves in place.
            l_q    <= lf;
            data_q <= {lf, r_q};
          end else begin
            l_q     <= r_q;
            r_q     <= lf;
            round_q <= round_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seed_round_ctrl.sv
module tb_seed_round_ctrl;

  localparam int NR   = 16;
  localparam int LAT0 = 1 + NR * 4 + 1;
  localparam int LAT1 = 1 + NR * 7 + 1;

  localparam logic [2047:0] S1_TAB = {
    128'hA985D6D3541DAC255D43181E51FCCA63, 128'h2844209DE0E2C817A58F037BBB13D2EE,
    128'h708C3FA832DDF674EC950B575C5BBD01, 128'h241C739810CCF2D92CE772839BD186C9,
    128'h6050A3EB0DB69E4FB75AC678A612AFD5, 128'h61C3B441527D8D081F9900190453F7E1,
    128'hFD762F27B08B0EABA26E934D697C090A, 128'hBFEFF3C58714FE64DE2E4B1A06216B66,
    128'h02F5928A0CB37ED07A4796E52680ADDF, 128'hA13037AE36152238F4A7454C81E98497,
    128'h35CBCE3C7111C78975FBDAF8945982C4, 128'hFF493967C0CFD7B80F8E4223916CDBA4,
    128'h34F148C26F3D2D40BE3EBCC1AABA4E55, 128'h3BDC687F9CD84A5677A0ED46B52B65FA,
    128'hE3B9B19F5EF9E6B231EA6D5FE4F0CD88, 128'h163A58D462290733E81B0579906A2A9A
  };
  localparam logic [2047:0] S2_TAB = {
    128'h38E82DA6CFDEB3B8AF6055C7446F6B5B, 128'hC36233B529A0E2A7D39111061CBC364B,
    128'hEF886CA817C416F4C245E1D63F3D8E98, 128'h284EF63EA5F90DDFD82B667A272FF172,
    128'h42D441C07367AC8BF7AD801FCA2CAA34, 128'hD20BEEE95D9418F857AE08C513CD86B9,
    128'hFF7DC131F58A6AB1D120D70222046871, 128'h07DB9D9961BEE659DD5190DC9AA3ABD0,
    128'h810F471AE3EC8DBF967B5CA2A163234D, 128'hC89E9C3A0C2EBA6E9F5AF292F34978CC,
    128'h15FB70757F351003646DC674D5B4EA09, 128'h7619FE4012E0BD05FA01F02A5EA95643,
    128'h8514899BB0E5487997FC1E82218C1B5F, 128'h7754B21D254F0046ED5852EB7EDAC9FD,
    128'h3095653CB6E4BB7C0E50392632846993, 128'h37E724A4CB530A87D94C838FCE3B4AB7
  };

  localparam logic [127:0] T1_KEY = 128'h0;
  localparam logic [127:0] T1_PT  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] T1_CT  = 128'h5EBAC6E0054E166819AFF1CC6D346CDB;
  localparam logic [127:0] T2_KEY = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] T2_PT  = 128'h0;
  localparam logic [127:0] T2_CT  = 128'hC11F22F20140505084483597E4370F43;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [7:0]   s1 [256];
  logic [7:0]   s2 [256];
  logic [63:0]  rk [16];
  logic [127:0] exp_q [$];

  int n_checks = 0;
  int n_errors = 0;
  int vcnt0 = 0;
  int vcnt1 = 0;

  seed_round_ctrl_if bus0 ();
  seed_round_ctrl_if bus1 ();

  assign bus0.i_RoundKey = rk[bus0.o_KeyIdx];
  assign bus1.i_RoundKey = rk[bus1.o_KeyIdx];

  seed_round_ctrl #(.NUM_ROUNDS(NR), .G_REG(1'b0)) dut0 (
    .i_Clk(clk), .i_Rst_n(rst_n), .bus(bus0.slave)
  );
  seed_round_ctrl #(.NUM_ROUNDS(NR), .G_REG(1'b1)) dut1 (
    .i_Clk(clk), .i_Rst_n(rst_n), .bus(bus1.slave)
  );

  // ---------------- clock / valid monitor ----------------
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus0.o_Valid === 1'b1) vcnt0++;
    if (bus1.o_Valid === 1'b1) vcnt1++;
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_g(input logic [31:0] x);
    logic [7:0] a, b, c, e, z0, z1, z2, z3;
    a = s1[x[7:0]];
    b = s2[x[15:8]];
    c = s1[x[23:16]];
    e = s2[x[31:24]];
    z0 = (a & 8'hFC) ^ (b & 8'hF3) ^ (c & 8'hCF) ^ (e & 8'h3F);
    z1 = (a & 8'hF3) ^ (b & 8'hCF) ^ (c & 8'h3F) ^ (e & 8'hFC);
    z2 = (a & 8'hCF) ^ (b & 8'h3F) ^ (c & 8'hFC) ^ (e & 8'hF3);
    z3 = (a & 8'h3F) ^ (b & 8'hFC) ^ (c & 8'hF3) ^ (e & 8'hCF);
    return {z3, z2, z1, z0};
  endfunction

  function automatic void key_sched(input logic [127:0] key);
    logic [31:0] a, b, c, d, kc;
    logic [63:0] t;
    a = key[127:96]; b = key[95:64]; c = key[63:32]; d = key[31:0];
    for (int i = 0; i < 16; i++) begin
      kc = (32'h9E3779B9 << i) | (32'h9E3779B9 >> (32 - i));
      rk[i] = {ref_g(a + c - kc), ref_g(b - d + kc)};
      if (i % 2 == 0) begin
        t = {a, b};
        t = {t[7:0], t[63:8]};
        a = t[63:32]; b = t[31:0];
      end else begin
        t = {c, d};
        t = {t[55:0], t[63:56]};
        c = t[63:32]; d = t[31:0];
      end
    end
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] pt);
    logic [63:0] l, r, t;
    logic [31:0] c, d;
    l = pt[127:64]; r = pt[63:0];
    for (int i = 0; i < NR; i++) begin
      c = r[63:32] ^ rk[i][63:32];
      d = r[31:0] ^ rk[i][31:0];
      d = ref_g(c ^ d);
      c = ref_g(c + d);
      d = ref_g(c + d);
      c = c + d;
      t = l ^ {c, d};
      l = r;
      r = t;
    end
    return {r, l};
  endfunction

  // ---------------- checks ----------------
  task automatic check128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input int u, input logic st, input logic [127:0] dat);
    if (u == 0) begin bus0.i_Start = st; bus0.i_Data = dat; end
    else        begin bus1.i_Start = st; bus1.i_Data = dat; end
  endtask

  function automatic logic get_valid(input int u);
    return (u == 0) ? bus0.o_Valid : bus1.o_Valid;
  endfunction
  function automatic logic get_busy(input int u);
    return (u == 0) ? bus0.o_Busy : bus1.o_Busy;
  endfunction
  function automatic logic [127:0] get_data(input int u);
    return (u == 0) ? bus0.o_Data : bus1.o_Data;
  endfunction
  function automatic logic [3:0] get_kidx(input int u);
    return (u == 0) ? bus0.o_KeyIdx : bus1.o_KeyIdx;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // mode 0: quiet inputs, 1: i_Start every cycle with random data, 2: random data
  task automatic drive_run(input int u, input int mode);
    case (mode)
      1:       set_in(u, 1'b1, rnd128());
      2:       set_in(u, 1'b0, rnd128());
      default: set_in(u, 1'b0, '0);
    endcase
  endtask

  task automatic run_enc(input int u, input logic [127:0] pt, input int mode,
                         output int lat, output logic [127:0] ct, output logic got,
                         output int kidx_bad);
    int cpr;
    cpr = (u == 0) ? 4 : 7;
    lat = 1; got = 1'b0; ct = '0; kidx_bad = 0;
    set_in(u, 1'b1, pt);
    @(posedge clk); #1;
    lat = 2;
    while (!got && lat < 200) begin
      if (get_valid(u)) begin
        got = 1'b1;
        ct  = get_data(u);
      end else begin
        if (get_kidx(u) !== 4'((lat - 2) / cpr)) kidx_bad++;
        drive_run(u, mode);
        @(posedge clk); #1;
        lat++;
      end
    end
    set_in(u, 1'b0, '0);
  endtask

  task automatic do_op(input string tag, input int u, input logic [127:0] key,
                       input logic [127:0] pt, input int mode,
                       input bit use_kat, input logic [127:0] kat);
    int lat, kb, vc;
    logic [127:0] ct, exp;
    logic got;
    key_sched(key);
    exp_q.push_back(use_kat ? kat : model_enc(pt));
    vc = (u == 0) ? vcnt0 : vcnt1;
    check32({tag, "_idle_busy"}, 32'(get_busy(u)), 0);
    run_enc(u, pt, mode, lat, ct, got, kb);
    exp = exp_q.pop_front();
    check32({tag, "_done"}, 32'(got), 1);
    check128({tag, "_ct"}, ct, exp);
    check32({tag, "_lat"}, lat, (u == 0) ? LAT0 : LAT1);
    check32({tag, "_kidx_seq"}, kb, 0);
    check32({tag, "_kidx_done"}, 32'(get_kidx(u)), 0);
    check32({tag, "_busy_done"}, 32'(get_busy(u)), 0);
    @(posedge clk); #1;
    check32({tag, "_valid_pulse"}, 32'(get_valid(u)), 0);
    check128({tag, "_hold"}, get_data(u), exp);
    check32({tag, "_valid_cnt"}, ((u == 0) ? vcnt0 : vcnt1) - vc, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w, vc;
    for (int i = 0; i < 256; i++) begin
      s1[i] = S1_TAB[2047 - 8 * i -: 8];
      s2[i] = S2_TAB[2047 - 8 * i -: 8];
    end
    key_sched(T1_KEY);
    set_in(0, 1'b0, '0);
    set_in(1, 1'b0, '0);

    // reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int u = 0; u < 2; u++) begin
      check32("rst_busy", 32'(get_busy(u)), 0);
      check32("rst_valid", 32'(get_valid(u)), 0);
      check128("rst_data", get_data(u), '0);
      check32("rst_kidx", 32'(get_kidx(u)), 0);
    end

    // T1 / T2 known answers, single-cycle G
    do_op("t1", 0, T1_KEY, T1_PT, 0, 1'b1, T1_CT);
    do_op("t2", 0, T2_KEY, T2_PT, 0, 1'b1, T2_CT);
    // T2 with registered G
    do_op("t2_greg", 1, T2_KEY, T2_PT, 0, 1'b1, T2_CT);
    do_op("t1_greg", 1, T1_KEY, T1_PT, 0, 1'b1, T1_CT);

    // T3 start spam during a run
    do_op("t3", 0, T1_KEY, T1_PT, 1, 1'b1, T1_CT);

    // T4 asynchronous reset at round 7
    key_sched(T1_KEY);
    vc = vcnt0;
    set_in(0, 1'b1, T1_PT);
    @(posedge clk); #1;
    set_in(0, 1'b0, '0);
    w = 0;
    while (bus0.o_KeyIdx !== 4'd7 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check32("t4_reach_r7", 32'(bus0.o_KeyIdx), 7);
    #2 rst_n = 1'b0;
    #1;
    check32("t4_busy", 32'(bus0.o_Busy), 0);
    check128("t4_data", bus0.o_Data, '0);
    check32("t4_valid", 32'(bus0.o_Valid), 0);
    check32("t4_kidx", 32'(bus0.o_KeyIdx), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    check32("t4_no_valid", vcnt0 - vc, 0);
    do_op("t4_restart", 0, T1_KEY, T1_PT, 0, 1'b1, T1_CT);

    // T5 back to back: second start in the cycle after the valid pulse
    do_op("t5_a", 0, T1_KEY, T1_PT, 0, 1'b1, T1_CT);
    do_op("t5_b", 0, T2_KEY, T2_PT, 0, 1'b1, T2_CT);

    // T6 input data scrambled after the start cycle
    do_op("t6", 0, T1_KEY, T1_PT, 2, 1'b1, T1_CT);
    do_op("t6_greg", 1, T1_KEY, T1_PT, 2, 1'b1, T1_CT);

    // random keys/plaintexts against the model, both G variants
    for (int n = 0; n < 6; n++) begin
      do_op("rnd", n % 2, rnd128(), rnd128(), int'($urandom_range(0, 2)), 1'b0, '0);
    end

    check32("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
